// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Final pipeline stage. Non-memory results retire to the
//                register file one cycle after acceptance; loads and stores
//                issue a held bus request and stall the pipeline (o_ready low)
//                until the bus acknowledges. Loads then write the returned
//                data back; stores retire with no register write.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int RW    = 16,
    parameter int REGNO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    input  logic             i_mem_ack,
    input  logic [RW-1:0]    i_mem_data,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEM  = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic             mem_req_q,  mem_req_d;
    logic             mem_we_q,   mem_we_d;
    logic [RW-1:0]    mem_addr_q, mem_addr_d;
    logic [RW-1:0]    mem_data_q, mem_data_d;
    logic [REGNO-1:0] lat_ie_q,   lat_ie_d;    // destination held while the bus access is in flight
    logic [REGNO-1:0] reg_ie_q,   reg_ie_d;
    logic [RW-1:0]    reg_data_q, reg_data_d;

    // Ready depends on state alone so execute never sees a path from submit or ack.
    assign o_ready    = (state_q == ST_IDLE);
    assign o_mem_req  = mem_req_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    assign o_reg_ie   = reg_ie_q;
    assign o_reg_data = reg_data_q;

    // Next-state: accept in IDLE, wait for ack in MEM; writeback enable is a one-cycle pulse.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        lat_ie_d   = lat_ie_q;
        reg_ie_d   = '0;
        reg_data_d = reg_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_submit) begin
                    if (!i_mem_access) begin
                        reg_ie_d   = i_reg_ie;
                        reg_data_d = i_data;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = i_mem_we;
                        mem_addr_d = i_addr;
                        mem_data_d = i_data;
                        lat_ie_d   = i_reg_ie;
                        state_d    = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                    // Stores never write the register file, whatever destination came with them.
                    if (!mem_we_q) begin
                        reg_ie_d   = lat_ie_q;
                        reg_data_d = i_mem_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access without writeback.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            lat_ie_q   <= '0;
            reg_ie_q   <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            lat_ie_q   <= lat_ie_d;
            reg_ie_q   <= reg_ie_d;
            reg_data_q <= reg_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage. Directed scenarios are
//                followed by randomized transactions; expected results come
//                from a per-transaction reference model with a bus responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int RW    = 16;
    localparam int REGNO = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             submit = 1'b0;
    logic             ready;
    logic [RW-1:0]    data = '0;
    logic [RW-1:0]    addr = '0;
    logic [REGNO-1:0] reg_ie = '0;
    logic             mem_access = 1'b0;
    logic             mem_we_in = 1'b0;
    logic             mem_req;
    logic             mem_we;
    logic [RW-1:0]    mem_addr;
    logic [RW-1:0]    mem_wdata;
    logic             mem_ack = 1'b0;
    logic [RW-1:0]    mem_rdata = '0;
    logic [REGNO-1:0] wb_ie;
    logic [RW-1:0]    wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view kept by the model: last value written to the register-file port.
    logic [RW-1:0] last_wb;

    mem_wb_stage #(.RW(RW), .REGNO(REGNO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_submit     (submit),
        .o_ready      (ready),
        .i_data       (data),
        .i_addr       (addr),
        .i_reg_ie     (reg_ie),
        .i_mem_access (mem_access),
        .i_mem_we     (mem_we_in),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_data   (mem_rdata),
        .o_reg_ie     (wb_ie),
        .o_reg_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle with no instruction; a stray ack must have no effect.
    task automatic idle_cycle(input logic stray_ack);
        @(negedge clk);
        submit  = 1'b0;
        mem_ack = stray_ack;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("idle_ready", ready, 1);
        chk("idle_req", mem_req, 0);
        chk("idle_ie", wb_ie, 0);
        chk("idle_data", wb_data, last_wb);
    endtask

    // ALU op: retires one cycle after acceptance, stage stays ready.
    task automatic alu_op(input logic [RW-1:0] d, input logic [REGNO-1:0] ie);
        @(negedge clk);
        chk("alu_ready_pre", ready, 1);
        submit     = 1'b1;
        data       = d;
        reg_ie     = ie;
        mem_access = 1'b0;
        mem_we_in  = 1'($urandom);
        addr       = RW'($urandom);
        mem_ack    = 1'($urandom);
        @(posedge clk); #1;
        submit  = 1'b0;
        mem_ack = 1'b0;
        last_wb = d;
        chk("alu_wb_ie", wb_ie, ie);
        chk("alu_wb_data", wb_data, d);
        chk("alu_ready", ready, 1);
        chk("alu_req", mem_req, 0);
    endtask

    // Memory op with the bus acking after 'lat' extra request cycles.
    // With 'junk', submit stays high with a different ALU payload throughout the access;
    // it must be taken exactly once, right after the stage returns ready.
    task automatic mem_op(input logic [RW-1:0] a, input logic [RW-1:0] d, input logic we,
                          input logic [REGNO-1:0] ie, input int lat, input logic junk,
                          input logic [RW-1:0] rd);
        logic [RW-1:0]    jd;
        logic [REGNO-1:0] jie;
        jd  = ~d;
        jie = REGNO'(1) << $urandom_range(REGNO-1, 0);
        @(negedge clk);
        chk("mem_ready_pre", ready, 1);
        submit     = 1'b1;
        addr       = a;
        data       = d;
        mem_we_in  = we;
        reg_ie     = ie;
        mem_access = 1'b1;
        @(posedge clk); #1;
        if (junk) begin
            data       = jd;
            reg_ie     = jie;
            mem_access = 1'b0;
            addr       = ~a;
        end else begin
            submit = 1'b0;
        end
        for (int k = 0; k <= lat; k++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, d);
            chk("mem_ready_busy", ready, 0);
            chk("mem_ie_busy", wb_ie, 0);
            @(negedge clk);
            if (k == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_rdata = RW'($urandom);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (!we) last_wb = rd;
        chk("mem_req_done", mem_req, 0);
        chk("mem_we_done", mem_we, 0);
        chk("mem_ready_done", ready, 1);
        chk("mem_wb_ie", wb_ie, we ? '0 : ie);
        chk("mem_wb_data", wb_data, last_wb);
        if (junk) begin
            @(posedge clk); #1;
            submit  = 1'b0;
            last_wb = jd;
            chk("junk_wb_ie", wb_ie, jie);
            chk("junk_wb_data", wb_data, jd);
            chk("junk_ready", ready, 1);
            idle_cycle(1'b0);
        end
    endtask

    initial begin
        last_wb = '0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ie", wb_ie, 0);
        chk("rst_data", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU retire, then pulse returns to zero
        alu_op(16'h1234, 8'b0000_0100);
        idle_cycle(1'b0);
        // Load: request high exactly 3 cycles
        mem_op(16'h0040, 16'h0000, 1'b0, 8'b0000_0010, 2, 1'b0, 16'hBEEF);
        // Store acked in first request cycle
        mem_op(16'h0100, 16'hCAFE, 1'b1, 8'b0000_0001, 0, 1'b0, 16'h5555);
        idle_cycle(1'b0);
        // Back-to-back ALU ops
        for (int i = 1; i <= 4; i++) alu_op(RW'(i), REGNO'(1) << i);
        idle_cycle(1'b0);
        // Submit held during MEM with a different payload
        mem_op(16'h0200, 16'h0F0F, 1'b0, 8'b0001_0000, 3, 1'b1, 16'hA5A5);

        // Reset in the middle of a load
        @(negedge clk);
        submit = 1'b1; addr = 16'h0300; data = 16'h0; mem_we_in = 1'b0;
        reg_ie = 8'b1000_0000; mem_access = 1'b1;
        @(posedge clk); #1;
        submit = 1'b0;
        chk("rstmid_req_before", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        last_wb = '0;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_ready", ready, 1);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_data", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(3, 0))
                0, 1: alu_op(RW'($urandom), REGNO'($urandom));
                2: mem_op(RW'($urandom), RW'($urandom), 1'($urandom), REGNO'($urandom),
                          int'($urandom_range(4, 0)), 1'($urandom_range(3, 0) == 0),
                          RW'($urandom));
                default: idle_cycle(1'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage; consumes the execute stage's next-stage interface (data, address, register write enables, memory-access flags, submit/ready).
- Performs the memory access on the data bus when required, then drives the register-file write port (reg_ie/reg_data) back to execute.
- Non-memory results retire with 1-cycle latency.
- Loads and stores hold the pipeline via o_ready until the bus acknowledges.

Parameters:
RW, 16, datapath/address width
REGNO, 8, number of architectural registers (width of one-hot register write enable)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_submit  input  1  execute presents a valid instruction this cycle
o_ready  output  1  stage can accept an instruction this cycle
i_data  input  RW  ALU/sreg result, or store data when i_mem_access
i_addr  input  RW  memory address
i_reg_ie  input  REGNO  one-hot destination register write enable (may be zero)
i_mem_access  input  1  instruction accesses memory
i_mem_we  input  1  memory access is a store
o_mem_req  output  1  bus request, held until ack
o_mem_we  output  1  bus write strobe, valid with o_mem_req
o_mem_addr  output  RW  bus address
o_mem_data  output  RW  bus write data
i_mem_ack  input  1  bus completes the current request
i_mem_data  input  RW  bus read data, valid with i_mem_ack
o_reg_ie  output  REGNO  register-file write enable, 1-cycle pulse
o_reg_data  output  RW  register-file write data

Behaviour:
- Async reset (i_rst_n low): state=IDLE; o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_reg_ie=0, o_reg_data=0. Takes effect immediately, including mid-access; a pending request is dropped without writeback.
- o_ready = (state==IDLE), combinational from state only. No combinational path from i_submit or i_mem_ack.
- Accept = i_submit & o_ready. i_submit while not ready is ignored; execute holds its instruction.
- o_reg_ie defaults to 0 every cycle unless a writeback occurs. o_reg_data holds its last value when o_reg_ie=0.
- States:
  - IDLE:
    - Accept with i_mem_access=0: next cycle o_reg_ie=i_reg_ie, o_reg_data=i_data; stay IDLE (back-to-back issue allowed).
    - Accept with i_mem_access=1: next cycle o_mem_req=1, o_mem_we=i_mem_we, o_mem_addr=i_addr, o_mem_data=i_data; latch i_reg_ie; go MEM.
  - MEM:
    - o_mem_req/we/addr/data stable until the ack cycle.
    - On i_mem_ack: next cycle o_mem_req=0, o_mem_we=0, state=IDLE.
    - Load: in that same next cycle o_reg_ie=latched reg_ie, o_reg_data=i_mem_data sampled at ack.
    - Store: no writeback; o_reg_ie=0 even if latched reg_ie was nonzero.
- Ack in the first cycle o_mem_req is high is valid: minimum load retire = 2 cycles after accept. No timeout; MEM waits indefinitely.
- i_mem_ack while o_mem_req=0 is ignored.
- No flush input: an accepted instruction always completes, because execute raises flush only for older stages.
- Writeback pulse coincides with o_ready returning high. A new instruction may be accepted in that same cycle.
- Address/data are passed unmodified; no width conversion or sign handling.

Test Plan:
1. Reset, then submit i_data=16'h1234, i_reg_ie=8'b0000_0100, i_mem_access=0 -> next cycle o_reg_ie=8'b0000_0100, o_reg_data=16'h1234; o_ready stays 1; following cycle o_reg_ie=0.
2. Load: i_addr=16'h0040, i_mem_we=0, i_reg_ie=8'b0000_0010; i_mem_ack high 3 cycles after o_mem_req rises, i_mem_data=16'hBEEF -> o_mem_req high exactly 3 cycles with addr 16'h0040; o_ready low throughout; cycle after ack o_reg_ie=8'b0000_0010, o_reg_data=16'hBEEF, o_ready=1.
3. Store: i_addr=16'h0100, i_data=16'hCAFE, i_mem_we=1, i_reg_ie=8'b0000_0001; ack in first request cycle -> o_mem_we=1, o_mem_data=16'hCAFE for one cycle; no o_reg_ie pulse; o_ready back after 2 cycles.
4. Back-to-back ALU submits on 4 consecutive cycles (r1..r4, data 1..4) -> four consecutive writeback pulses in order, o_ready never low.
5. i_submit held high during MEM with a different payload -> payload ignored until o_ready=1, then accepted exactly once.
6. Assert i_rst_n low mid-load (o_mem_req=1) -> o_mem_req drops immediately; no writeback after release; stray i_mem_ack after release ignored; o_ready=1.
